alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have ports: clk_i  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid_i in 1 decode slot valid; in_ready_o out 1 stage can accept.
REQ-004 SHALL have ports: rs_data_i, rt_data_i in 32 register-file reads; rs_addr_i, rt_addr_i, rd_i in 5 register numbers.
REQ-005 SHALL have ports: imm_i in 32 sign/zero-extended immediate; alu_src_i in 1 (1 = immediate drives src2); ctrl_i in 4 ALU op code; shamt_i in 5 shift amount.
REQ-006 SHALL have ports: reg_write_i, mem_read_i in 1 write-back and load flags; flush_i in 1 kill held entry.
REQ-007 SHALL have ports: exmem_rd_i in 5, exmem_regwrite_i in 1, exmem_memread_i in 1, exmem_result_i in 32 (EX/MEM producer).
REQ-008 SHALL have ports: memwb_rd_i in 5, memwb_regwrite_i in 1, memwb_data_i in 32 (MEM/WB producer).
REQ-009 SHALL have ports: out_valid_o out 1; out_ready_i in 1 ALU side accepts.
REQ-010 SHALL have ports: src1_o, src2_o out 32; ctrl_o out 4; shamt_o out 5; rd_o out 5; reg_write_o, mem_read_o out 1.

Function
REQ-011 Stage SHALL hold one entry with states EMPTY, FULL, STALL.
REQ-012 in_ready_o SHALL equal (state==EMPTY) or (state==FULL and out_ready_i); never 1 in STALL.
REQ-013 On in_valid_i & in_ready_o the stage SHALL capture all decode inputs at the clock edge; state becomes FULL (or STALL if REQ-016 hazard holds for the new entry).
REQ-014 FULL with out_ready_i and no new capture SHALL go EMPTY; capture during drain SHALL stay FULL (back-to-back, zero bubble).
REQ-015 out_valid_o SHALL be 1 only in FULL; latency input-capture to out_valid_o = 1 cycle.
REQ-016 Load-use hazard: exmem_memread_i & exmem_regwrite_i & exmem_rd_i!=0 & exmem_rd_i matches held rs or rt (rt only if alu_src==0) SHALL move FULL->STALL; STALL SHALL return to FULL when hazard clears; entry unchanged during STALL.
REQ-017 src1_o SHALL be forwarded combinationally: exmem_result_i if exmem_regwrite_i, exmem_memread_i==0, exmem_rd_i!=0, exmem_rd_i==held rs; else memwb_data_i if memwb_regwrite_i, memwb_rd_i!=0, memwb_rd_i==held rs; else held rs_data.
REQ-018 src2_o SHALL be held imm when alu_src==1, else rt forwarded by REQ-017 priority rules.
REQ-019 Register 0 SHALL never be forwarded; both producers matching SHALL select EX/MEM.
REQ-020 flush_i SHALL force state EMPTY at next edge, overriding capture and STALL; reg_write_o/mem_read_o SHALL read 0 whenever state!=FULL.
REQ-021 ctrl_o, shamt_o, rd_o SHALL present held values unchanged while state is FULL or STALL.

Reset
REQ-022 rst_i low SHALL asynchronously set state EMPTY and clear all held fields to 0; out_valid_o=0, in_ready_o=1, all data outputs 0.
REQ-023 Reset mid-STALL or mid-handshake SHALL discard the entry; first capture allowed on first rising edge after rst_i high.

Configuration
REQ-024 Macro ALU_OPERAND_FWD_MEMWB_EN defined: MEM/WB forwarding per REQ-017 SHALL be present.
REQ-025 Macro undefined: memwb_* inputs SHALL be ignored; only EX/MEM forwarding or held register data used (register file assumed write-before-read).

Verification
REQ-026 Reset: rst_i=0 mid-FULL -> out_valid_o=0, src1_o=0, in_ready_o=1 immediately.
REQ-027 Forward priority: held rs=5, exmem_rd=5 result=0x11, memwb_rd=5 data=0x22 -> src1_o=0x11; exmem_regwrite=0 -> 0x22 (0x22 only with macro; else rs_data).
REQ-028 Zero reg: held rs=0, exmem_rd=0 regwrite=1 result=0xFF -> src1_o=held rs_data.
REQ-029 Load-use: held rt=8, alu_src=0, exmem_memread=1 rd=8 -> STALL, out_valid_o=0, in_ready_o=0 one cycle; memread drops -> FULL, src2_o=rt forwarded.
REQ-030 Throughput: in_valid_i and out_ready_i held 1 for 4 ops, ctrl 2,6,0,14 -> ctrl_o sequence 2,6,0,14 on consecutive cycles, no bubble.
REQ-031 Flush: flush_i=1 with in_valid_i=1 while STALL -> EMPTY next cycle, out_valid_o=0, reg_write_o=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// alu_operand_stage : one-entry operand latch between decode and the ALU with
// EX/MEM forwarding, load-use stall and flush. Optional MEM/WB forwarding is
// enabled by defining ALU_OPERAND_FWD_MEMWB_EN.   Revision: 1.0
// ============================================================================
module alu_operand_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  // decode side
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  input  logic        alu_src_i,
  input  logic [3:0]  ctrl_i,
  input  logic [4:0]  shamt_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        flush_i,
  // EX/MEM producer
  input  logic [4:0]  exmem_rd_i,
  input  logic        exmem_regwrite_i,
  input  logic        exmem_memread_i,
  input  logic [31:0] exmem_result_i,
  // MEM/WB producer
  input  logic [4:0]  memwb_rd_i,
  input  logic        memwb_regwrite_i,
  input  logic [31:0] memwb_data_i,
  // ALU side
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [3:0]  ctrl_o,
  output logic [4:0]  shamt_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [3:0]  ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
  } entry_t;

  state_e state_q, state_d;
  entry_t entry_q, entry_d, entry_in;

  logic is_empty, is_full, capture;
  logic load_pending, hazard_held, hazard_new;
  logic ex_fwd_ok, ex_hit_rs, ex_hit_rt;
  logic mw_hit_rs, mw_hit_rt;
  logic [31:0] rt_fwd;

  assign is_empty = (state_q == ST_EMPTY);
  assign is_full  = (state_q == ST_FULL);

  assign in_ready_o  = is_empty | (is_full & out_ready_i);
  assign out_valid_o = is_full;
  assign capture     = in_valid_i & in_ready_o;

  always_comb begin
    entry_in           = '0;
    entry_in.rs_data   = rs_data_i;
    entry_in.rt_data   = rt_data_i;
    entry_in.imm       = imm_i;
    entry_in.rs_addr   = rs_addr_i;
    entry_in.rt_addr   = rt_addr_i;
    entry_in.rd        = rd_i;
    entry_in.shamt     = shamt_i;
    entry_in.ctrl      = ctrl_i;
    entry_in.alu_src   = alu_src_i;
    entry_in.reg_write = reg_write_i;
    entry_in.mem_read  = mem_read_i;
  end

  // A load in EX/MEM cannot forward yet; any consumer of its rd must wait.
  assign load_pending = exmem_memread_i & exmem_regwrite_i & (exmem_rd_i != 5'd0);
  assign hazard_held  = load_pending &
                        ((exmem_rd_i == entry_q.rs_addr) |
                         (~entry_q.alu_src & (exmem_rd_i == entry_q.rt_addr)));
  assign hazard_new   = load_pending &
                        ((exmem_rd_i == rs_addr_i) |
                         (~alu_src_i & (exmem_rd_i == rt_addr_i)));

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      entry_d = entry_in;
      state_d = hazard_new ? ST_STALL : ST_FULL;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_FULL: begin
          if (out_ready_i) begin
            state_d = ST_EMPTY;
          end else if (hazard_held) begin
            state_d = ST_STALL;
          end
        end
        ST_STALL: begin
          if (!hazard_held) begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Register 0 is never forwarded; the rd != 0 term guarantees that.
  assign ex_fwd_ok = exmem_regwrite_i & ~exmem_memread_i & (exmem_rd_i != 5'd0);
  assign ex_hit_rs = ex_fwd_ok & (exmem_rd_i == entry_q.rs_addr);
  assign ex_hit_rt = ex_fwd_ok & (exmem_rd_i == entry_q.rt_addr);

`ifdef ALU_OPERAND_FWD_MEMWB_EN
  logic mw_fwd_ok;
  assign mw_fwd_ok = memwb_regwrite_i & (memwb_rd_i != 5'd0);
  assign mw_hit_rs = mw_fwd_ok & (memwb_rd_i == entry_q.rs_addr);
  assign mw_hit_rt = mw_fwd_ok & (memwb_rd_i == entry_q.rt_addr);
`else
  // Register file writes before it is read, so MEM/WB data is already in rs/rt_data.
  logic unused_memwb;
  assign unused_memwb = ^{memwb_rd_i, memwb_regwrite_i, memwb_data_i};
  assign mw_hit_rs    = 1'b0;
  assign mw_hit_rt    = 1'b0;
`endif

  assign src1_o = ex_hit_rs ? exmem_result_i :
                  mw_hit_rs ? memwb_data_i   : entry_q.rs_data;
  assign rt_fwd = ex_hit_rt ? exmem_result_i :
                  mw_hit_rt ? memwb_data_i   : entry_q.rt_data;
  assign src2_o = entry_q.alu_src ? entry_q.imm : rt_fwd;

  assign ctrl_o      = entry_q.ctrl;
  assign shamt_o     = entry_q.shamt;
  assign rd_o        = entry_q.rd;
  assign reg_write_o = entry_q.reg_write & is_full;
  assign mem_read_o  = entry_q.mem_read & is_full;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// tb_alu_operand_stage : randomized and directed checks of alu_operand_stage
// against a queue-based behavioural model.
module tb_alu_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i, in_ready_o;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_i, shamt_i;
  logic        alu_src_i, reg_write_i, mem_read_i, flush_i;
  logic [3:0]  ctrl_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_regwrite_i, exmem_memread_i, memwb_regwrite_i;
  logic [31:0] exmem_result_i, memwb_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] src1_o, src2_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  shamt_o, rd_o;
  logic        reg_write_o, mem_read_o;

  always #5 clk_i = ~clk_i;

  alu_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_i(rd_i),
    .imm_i(imm_i), .alu_src_i(alu_src_i), .ctrl_i(ctrl_i), .shamt_i(shamt_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_memread_i(exmem_memread_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .memwb_data_i(memwb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .shamt_o(shamt_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [3:0]  ctrl;
    logic        alu_src, rw, mr;
  } op_t;

  op_t held[$];      // zero or one operation in the stage
  bit  stalled  = 0;
  bit  pristine = 1; // nothing captured since reset: all data outputs read 0

  function automatic op_t cur_in();
    op_t e;
    e.rs_data = rs_data_i; e.rt_data = rt_data_i; e.imm = imm_i;
    e.rs = rs_addr_i; e.rt = rt_addr_i; e.rd = rd_i; e.shamt = shamt_i;
    e.ctrl = ctrl_i; e.alu_src = alu_src_i; e.rw = reg_write_i; e.mr = mem_read_i;
    return e;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && exmem_regwrite_i && !exmem_memread_i && exmem_rd_i == a) return exmem_result_i;
`ifdef ALU_OPERAND_FWD_MEMWB_EN
    if (a != 0 && memwb_regwrite_i && memwb_rd_i == a) return memwb_data_i;
`endif
    return d;
  endfunction

  function automatic bit load_blocks(input op_t e);
    return exmem_memread_i && exmem_regwrite_i && exmem_rd_i != 0 &&
           (exmem_rd_i == e.rs || (!e.alu_src && exmem_rd_i == e.rt));
  endfunction

  // Check every output against the model, advance the model, wait for the edge.
  task automatic tick();
    bit  full, rdy;
    op_t e;
    #1;
    full = (held.size() == 1) && !stalled;
    rdy  = (held.size() == 0) || (full && out_ready_i);
    check("out_valid", out_valid_o, full);
    check("in_ready", in_ready_o, rdy);
    if (held.size() == 1) begin
      e = held[0];
      check("reg_write", reg_write_o, full ? e.rw : 1'b0);
      check("mem_read", mem_read_o, full ? e.mr : 1'b0);
      check("src1", src1_o, fwd(e.rs, e.rs_data));
      check("src2", src2_o, e.alu_src ? e.imm : fwd(e.rt, e.rt_data));
      check("ctrl", ctrl_o, e.ctrl);
      check("shamt", shamt_o, e.shamt);
      check("rd", rd_o, e.rd);
    end else begin
      check("reg_write", reg_write_o, 0);
      check("mem_read", mem_read_o, 0);
      if (pristine) begin
        check("src1_rst", src1_o, 0);
        check("src2_rst", src2_o, 0);
        check("ctrl_rst", ctrl_o, 0);
      end
    end
    if (flush_i) begin
      held.delete(); stalled = 0;
    end else if (in_valid_i && rdy) begin
      e = cur_in();
      held.delete(); held.push_back(e);
      stalled = load_blocks(e); pristine = 0;
    end else if (full && out_ready_i) begin
      held.delete(); stalled = 0;
    end else if (held.size() == 1) begin
      stalled = load_blocks(held[0]);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_valid_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; rd_i = 0; shamt_i = 0; ctrl_i = 0;
    alu_src_i = 0; reg_write_i = 0; mem_read_i = 0; flush_i = 0;
    exmem_rd_i = 0; exmem_regwrite_i = 0; exmem_memread_i = 0; exmem_result_i = 0;
    memwb_rd_i = 0; memwb_regwrite_i = 0; memwb_data_i = 0; out_ready_i = 0;
  endtask

  task automatic op(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                    input logic [31:0] rtd, input logic asrc, input logic [3:0] c);
    in_valid_i = 1; rs_addr_i = rs; rs_data_i = rsd; rt_addr_i = rt; rt_data_i = rtd;
    alu_src_i = asrc; ctrl_i = c; imm_i = 32'h1000_0000 | {28'd0, c};
    rd_i = 5'd9; shamt_i = 5'd3; reg_write_i = 1; mem_read_i = 0;
  endtask

  logic [3:0] seq [4];

  initial begin
    idle();
    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_src1", src1_o, 0);
    @(negedge clk_i) rst_i = 1;
    @(posedge clk_i); #1;

    // back-to-back throughput
    seq[0] = 4'd2; seq[1] = 4'd6; seq[2] = 4'd0; seq[3] = 4'd14;
    out_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) op(5'd1, 32'h100 + i, 5'd2, 32'h200 + i, 1'b0, seq[i]);
      else in_valid_i = 0;
      tick();
      if (i < 4) begin
        check("tput_valid", out_valid_o, 1);
        check("tput_ctrl", ctrl_o, seq[i]);
      end
    end
    tick();

    // forwarding priority on rs=5
    out_ready_i = 0;
    op(5'd5, 32'hAAAA, 5'd6, 32'hBBBB, 1'b0, 4'd3);
    tick();
    in_valid_i = 0;
    exmem_rd_i = 5; exmem_regwrite_i = 1; exmem_result_i = 32'h11;
    memwb_rd_i = 5; memwb_regwrite_i = 1; memwb_data_i = 32'h22;
    #1 check("prio_exmem", src1_o, 32'h11);
    tick();
    exmem_regwrite_i = 0;
`ifdef ALU_OPERAND_FWD_MEMWB_EN
    #1 check("prio_memwb", src1_o, 32'h22);
`else
    #1 check("prio_memwb", src1_o, 32'hAAAA);
`endif
    tick();

    // register 0 never forwarded
    out_ready_i = 1;
    op(5'd0, 32'h1234, 5'd0, 32'h5678, 1'b0, 4'd4);
    tick();
    in_valid_i = 0; out_ready_i = 0;
    exmem_rd_i = 0; exmem_regwrite_i = 1; exmem_result_i = 32'hFF;
    memwb_rd_i = 0; memwb_data_i = 32'hFF;
    #1 check("zero_reg", src1_o, 32'h1234);
    tick();

    // load-use on rt=8
    out_ready_i = 1; memwb_regwrite_i = 0;
    op(5'd1, 32'h1, 5'd8, 32'h88, 1'b0, 4'd7);
    exmem_rd_i = 8; exmem_regwrite_i = 1; exmem_memread_i = 1; exmem_result_i = 32'h0;
    tick();
    in_valid_i = 0; out_ready_i = 0;
    #1 check("lu_valid", out_valid_o, 0);
    check("lu_ready", in_ready_o, 0);
    tick();
    exmem_memread_i = 0; exmem_result_i = 32'h77;
    tick();
    check("lu_resume", out_valid_o, 1);
    check("lu_src2", src2_o, 32'h77);
    tick();

    // flush while stalled
    exmem_memread_i = 1;
    tick();
    check("fl_stall", out_valid_o, 0);
    flush_i = 1;
    op(5'd8, 32'h3, 5'd8, 32'h4, 1'b0, 4'd1);
    tick();
    flush_i = 0; in_valid_i = 0;
    check("fl_valid", out_valid_o, 0);
    check("fl_regwr", reg_write_o, 0);
    check("fl_ready", in_ready_o, 1);
    tick();

    // asynchronous reset mid-FULL
    idle();
    op(5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 1'b0, 4'd5);
    tick();
    in_valid_i = 0;
    rst_i = 0;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_src1", src1_o, 0);
    check("arst_ready", in_ready_o, 1);
    held.delete(); stalled = 0; pristine = 1;
    @(negedge clk_i) rst_i = 1;
    @(posedge clk_i); #1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid_i       = ($urandom_range(0, 9) < 7);
      out_ready_i      = ($urandom_range(0, 9) < 6);
      flush_i          = ($urandom_range(0, 19) == 0);
      rs_addr_i        = 5'($urandom_range(0, 3));
      rt_addr_i        = 5'($urandom_range(0, 3));
      rd_i             = 5'($urandom);
      rs_data_i        = $urandom;
      rt_data_i        = $urandom;
      imm_i            = $urandom;
      alu_src_i        = 1'($urandom);
      ctrl_i           = 4'($urandom);
      shamt_i          = 5'($urandom);
      reg_write_i      = 1'($urandom);
      mem_read_i       = 1'($urandom);
      exmem_rd_i       = 5'($urandom_range(0, 3));
      exmem_regwrite_i = 1'($urandom);
      exmem_memread_i  = ($urandom_range(0, 9) < 3);
      exmem_result_i   = $urandom;
      memwb_rd_i       = 5'($urandom_range(0, 3));
      memwb_regwrite_i = 1'($urandom);
      memwb_data_i     = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
